resp_serializer: RTL and testbench
==================================

Name: resp_serializer

Overview:
Sits between resp_fifo and the byte-level UART transmitter. It pops one response packet at a time from resp_fifo, which is a first-word-fall-through FIFO. It frames the packet as a fixed 5-byte sequence: start-of-frame, opcode/status, address, data, check byte. It then hands the bytes out one at a time over a valid/ready handshake. It also enforces an optional idle gap between frames and keeps a count of frames sent.

Parameters:
- SOF_BYTE, 8'hA5, first byte of every frame.
- GAP_CYCLES, 0, number of clk cycles to hold idle after the last byte of a frame is accepted; 0 means no gap.
- CNT_W, 16, width of frame_count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- resp_valid  in  1  resp_fifo holds data; resp_data is valid (FWFT).
- resp_data  in  $bits(resp_packet_t)  head-of-FIFO response packet.
- resp_rd_en  out  1  one-cycle pop strobe to resp_fifo.
- tx_byte  out  8  byte offered to the UART transmitter.
- tx_valid  out  1  tx_byte is valid.
- tx_ready  in  1  transmitter accepts tx_byte on a cycle where tx_valid && tx_ready.
- busy  out  1  high in any state other than IDLE.
- frame_count  out  CNT_W  number of frames fully sent; wraps at 2^CNT_W.

Behaviour:
- Reset (rst_n==0 at a clk edge):
  - state=IDLE; resp_rd_en=0; tx_valid=0; tx_byte=8'h00; busy=0; frame_count=0; byte index=0; gap counter=0.
  - Takes priority over everything. Mid-frame reset abandons the frame, with no pop and no count.
- States: IDLE, SEND, GAP.
- IDLE:
  - If resp_valid is sampled 1 in cycle N, the FSM latches resp_data into frame regs at the end of N and moves to SEND.
  - In cycle N+1: resp_rd_en=1 for exactly one cycle, tx_valid=1, tx_byte=SOF_BYTE, index=0.
  - If resp_valid=0, the FSM stays in IDLE.
- Frame bytes: idx0=SOF_BYTE, idx1=opcode, idx2=addr, idx3=data, idx4=check.
  - Default check = opcode ^ addr ^ data.
  - The check byte is computed from the latched registers, never from live resp_data.
- SEND:
  - tx_valid is held at 1.
  - tx_byte must stay stable while tx_valid && !tx_ready; stalls may be of any length.
  - On each accept, the index increments and the next byte appears in the following cycle. No bubble is allowed between bytes when tx_ready is held at 1.
  - When idx4 is accepted: frame_count increments (wrapping), tx_valid=0 next cycle, and next state is GAP if GAP_CYCLES>0, else IDLE.
  - With tx_ready held at 1, a frame occupies exactly 5 tx cycles.
- GAP:
  - tx_valid=0. The counter loads GAP_CYCLES-1 on entry and counts down; on reaching 0 the FSM goes to IDLE.
  - resp_valid is ignored during GAP.
- Back-to-back frames with GAP_CYCLES=0:
  - The IDLE cycle that samples the next resp_valid is the only idle cycle between frames.
  - Minimum period is 6 cycles per frame.
- The FSM never pops while resp_valid=0. resp_valid dropping during SEND has no effect.
- tx_ready is ignored when tx_valid=0.
- busy = (state != IDLE).

Optional Feature:
- Macro: RESP_CRC8_EN.
- Defined: the check byte is CRC-8 with polynomial 0x07, init 0x00, no reflection, no final XOR. It covers idx1..idx3 in order. It is computed combinationally from the latched registers in the same cycle as the latch, so frame timing is identical to the XOR variant.
- Undefined: XOR check as above, and no CRC logic is synthesised.

Decomposition:
- cmd_pkg, extended:
  - resp_packet_t: packed struct with opcode[7:0], addr[7:0], data[7:0].
  - Constants RESP_FRAME_LEN=5 and RESP_SOF_DEFAULT=8'hA5.
  - The CRC8_POLY=8'h07 localparam.
  - The state enum resp_ser_state_t.
- One sub-module, crc8_calc: a combinational 3-byte CRC-8. It is instantiated only under RESP_CRC8_EN.

Test Plan:
1. Reset, then one packet {op=8'h02, addr=8'h10, data=8'h3C}, tx_ready=1 -> bytes A5,02,10,3C,2E on 5 consecutive cycles. resp_rd_en is a single pulse. frame_count=1.
2. Same packet with tx_ready toggled 1,0,0,1… -> same 5 bytes in order. Each byte is held stable during stalls. No duplicates and no drops.
3. Two packets queued back-to-back, GAP_CYCLES=0 -> frames start 6 cycles apart and there are exactly 2 resp_rd_en pulses. With GAP_CYCLES=3, the second SOF is seen 3 cycles later.
4. Drive rst_n=0 while byte idx2 is offered -> the next cycle shows tx_valid=0, busy=0, frame_count=0 and no pop. After release, a new frame starts with A5.
5. frame_count preset to 16'hFFFF via 65535 frames (or a forced preload) -> after one more frame, frame_count=0.
6. RESP_CRC8_EN defined, packet {op=8'h01, addr=8'h02, data=8'h03} -> check byte 8'h48. Timing is identical to scenario 1.

Source files
------------

// File: rtl/cmd_pkg.sv
// cmd_pkg: shared response packet type, frame constants and serializer states
package cmd_pkg;
  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] addr;
    logic [7:0] data;
  } resp_packet_t;
  localparam int RESP_FRAME_LEN = 5;
  localparam logic [7:0] RESP_SOF_DEFAULT = 8'hA5;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  typedef enum logic [1:0] {IDLE, SEND, GAP} resp_ser_state_t;
endpackage

// File: rtl/crc8_calc.sv
// crc8_calc: combinational CRC-8 (poly 0x07, init 0, no reflection) over three bytes, MSB byte first
module crc8_calc
  import cmd_pkg::*;
(
  input  logic [23:0] din,
  output logic [7:0]  crc
);
  always_comb begin
    crc = 8'h00;
    for (int i = 23; i >= 0; i--)
      crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ din[i]) ? CRC8_POLY : 8'h00);
  end
endmodule

// File: rtl/resp_serializer.sv
// resp_serializer: frames FWFT response packets into 5 bytes (SOF, op, addr, data, check) on a valid/ready byte stream
// Define RESP_CRC8_EN to use a CRC-8 check byte instead of the XOR of the payload bytes.
module resp_serializer
  import cmd_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE   = RESP_SOF_DEFAULT,
  parameter int         GAP_CYCLES = 0,
  parameter int         CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               resp_valid,
  input  resp_packet_t       resp_data,
  output logic               resp_rd_en,
  output logic [7:0]         tx_byte,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_count
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  resp_ser_state_t state, state_nx;
  logic [2:0]    idx;
  logic [GW-1:0] gap_cnt;
  resp_packet_t  frame;
  logic          pop;
  logic [7:0]    chk;
  logic          start, accept, last;
`ifdef RESP_CRC8_EN
  crc8_calc u_crc (.din(frame), .crc(chk));
`else
  assign chk = frame.opcode ^ frame.addr ^ frame.data;
`endif
  always_comb begin
    start    = (state == IDLE) && resp_valid;
    accept   = (state == SEND) && tx_ready;
    last     = idx == 3'(RESP_FRAME_LEN - 1);
    state_nx = start ? SEND
             : (accept && last) ? ((GAP_CYCLES > 0) ? GAP : IDLE)
             : (state == GAP && gap_cnt == '0) ? IDLE
             : state;
    tx_valid   = state == SEND;
    busy       = state != IDLE;
    resp_rd_en = pop;
    tx_byte    = (state != SEND) ? 8'h00
               : (idx == 3'd0) ? SOF_BYTE
               : (idx == 3'd1) ? frame.opcode
               : (idx == 3'd2) ? frame.addr
               : (idx == 3'd3) ? frame.data
               : chk;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 3'd0;
      gap_cnt     <= '0;
      pop         <= 1'b0;
      frame       <= '0;
      frame_count <= '0;
    end else begin
      state <= state_nx;
      pop   <= start;
      if (start) frame <= resp_data;
      if (accept) idx <= last ? 3'd0 : idx + 3'd1;
      if (accept && last) frame_count <= frame_count + 1'b1;
      gap_cnt <= (accept && last) ? GW'(GAP_CYCLES - 1)
               : (state == GAP && gap_cnt != '0) ? gap_cnt - 1'b1
               : gap_cnt;
    end
  end
endmodule

// File: tb/tb_resp_serializer.sv
// tb_resp_serializer: table-driven bench for resp_serializer with FWFT queue models and byte monitors
module tb_resp_serializer;
  import cmd_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, tx_ready = 1'b1;
  always #5 clk = ~clk;
  logic rv0 = 1'b0, rd0, tv0, busy0;
  logic rv1 = 1'b0, rd1, tv1, busy1;
  resp_packet_t d0 = '0, d1 = '0;
  logic [7:0] txb0, txb1;
  logic [15:0] fc0;
  logic [1:0] fc1;
  resp_serializer dut0 (
    .clk(clk), .rst_n(rst_n), .resp_valid(rv0), .resp_data(d0), .resp_rd_en(rd0),
    .tx_byte(txb0), .tx_valid(tv0), .tx_ready(tx_ready), .busy(busy0), .frame_count(fc0)
  );
  resp_serializer #(.GAP_CYCLES(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .resp_valid(rv1), .resp_data(d1), .resp_rd_en(rd1),
    .tx_byte(txb1), .tx_valid(tv1), .tx_ready(tx_ready), .busy(busy1), .frame_count(fc1)
  );
  resp_packet_t q0[$], q1[$];
  logic [7:0] rx0[$], rx1[$];
  int ts0[$], ts1[$];
  int cyc = 0, rdc0 = 0, rdc1 = 0, tests = 0, fails = 0;
  logic stall0 = 1'b0;
  logic [7:0] held0 = 8'h00;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // FWFT FIFO models: pop on the strobe seen at the edge, then present the new head
  always @(posedge clk) begin
    cyc++;
    if (rd0) begin rdc0++; if (q0.size() > 0) void'(q0.pop_front()); end
    if (rd1) begin rdc1++; if (q1.size() > 0) void'(q1.pop_front()); end
    #1;
    rv0 = q0.size() > 0;
    d0  = (q0.size() > 0) ? q0[0] : '0;
    rv1 = q1.size() > 0;
    d1  = (q1.size() > 0) ? q1[0] : '0;
  end
  always @(negedge clk) begin
    if (!rst_n) stall0 = 1'b0;
    else begin
      if (stall0) chk("stall_hold", {23'd0, tv0, txb0}, {23'd0, 1'b1, held0});
      if (tv0 && tx_ready) begin rx0.push_back(txb0); ts0.push_back(cyc); end
      if (tv1 && tx_ready) begin rx1.push_back(txb1); ts1.push_back(cyc); end
      stall0 = tv0 && !tx_ready;
      held0  = txb0;
    end
  end
  typedef struct {
    resp_packet_t p;
    logic [7:0]   xchk;
  } vec_t;
  vec_t vec[4];
`ifdef RESP_CRC8_EN
  function automatic logic [7:0] crc_model(resp_packet_t p);
    logic [23:0] w = p;
    logic [7:0] c = 8'h00;
    for (int j = 2; j >= 0; j--) begin
      c ^= w[j*8 +: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
  function automatic logic [7:0] exp_chk(vec_t v);
    return crc_model(v.p);
  endfunction
`else
  function automatic logic [7:0] exp_chk(vec_t v);
    return v.xchk;
  endfunction
`endif
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic wait_rx0(int n);
    int k = 0;
    while (rx0.size() < n && k < 200) begin @(negedge clk); #1; k++; end
    if (rx0.size() < n) chk("rx0_timeout", rx0.size(), n);
  endtask
  task automatic wait_rx1(int n);
    int k = 0;
    while (rx1.size() < n && k < 200) begin @(negedge clk); #1; k++; end
    if (rx1.size() < n) chk("rx1_timeout", rx1.size(), n);
  endtask
  task automatic check_frame(int base, vec_t v, bit timed);
    logic [7:0] e[5];
    e = '{8'hA5, v.p.opcode, v.p.addr, v.p.data, exp_chk(v)};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("byte%0d", i), (rx0.size() > base + i) ? rx0[base+i] : 8'hxx, e[i]);
      if (timed && i > 0 && rx0.size() > base + i) chk($sformatf("ts%0d", i), ts0[base+i] - ts0[base], i);
    end
  endtask
  initial begin
    int base, r;
    logic pat[4];
    vec[0] = '{'{8'h02, 8'h10, 8'h3C}, 8'h2E};
    vec[1] = '{'{8'h01, 8'h02, 8'h03}, 8'h00};
    vec[2] = '{'{8'hAA, 8'h55, 8'h01}, 8'hFE};
    vec[3] = '{'{8'h80, 8'h40, 8'h21}, 8'hE1};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    step(3);
    @(negedge clk); #1;
    chk("rst_tv", tv0, 0); chk("rst_tx_byte", txb0, 0); chk("rst_busy", busy0, 0);
    chk("rst_fc", fc0, 0); chk("rst_rd", rd0, 0); chk("rst_busy1", busy1, 0);
    step(1); rst_n = 1'b1; step(2);
    for (int i = 0; i < 4; i++) begin
      base = rx0.size(); r = rdc0;
      q0.push_back(vec[i].p);
      wait_rx0(base + 5);
      step(2);
      check_frame(base, vec[i], 1'b1);
      chk("pops", rdc0 - r, 1);
      chk("fc", fc0, i + 1);
      chk("idle_busy", busy0, 0);
    end
    base = rx0.size(); r = rdc0;
    q0.push_back(vec[0].p);
    for (int k = 0; k < 60 && rx0.size() < base + 5; k++) begin
      tx_ready = pat[k % 4];
      step(1);
    end
    tx_ready = 1'b1;
    step(3);
    chk("stall_count", rx0.size() - base, 5);
    check_frame(base, vec[0], 1'b0);
    chk("stall_pops", rdc0 - r, 1);
    chk("stall_fc", fc0, 5);
    base = rx0.size(); r = rdc0;
    q0.push_back(vec[0].p); q0.push_back(vec[1].p);
    wait_rx0(base + 10);
    step(2);
    check_frame(base, vec[0], 1'b1);
    check_frame(base + 5, vec[1], 1'b1);
    if (rx0.size() >= base + 10) chk("b2b_period", ts0[base+5] - ts0[base], 6);
    chk("b2b_pops", rdc0 - r, 2);
    q1.push_back(vec[2].p); q1.push_back(vec[3].p);
    wait_rx1(10);
    step(2);
    if (rx1.size() >= 10) begin
      chk("gap_period", ts1[5] - ts1[0], 9);
      chk("gap_sof2", rx1[5], 8'hA5);
      chk("gap_chk2", rx1[9], exp_chk(vec[3]));
    end
    chk("gap_pops", rdc1, 2);
    chk("gap_fc", fc1, 2);
    q1.push_back(vec[0].p); q1.push_back(vec[1].p);
    wait_rx1(20);
    step(2);
    if (rx1.size() >= 20) chk("gap_period2", ts1[15] - ts1[10], 9);
    chk("fc_wrap", fc1, 0);
    base = rx0.size(); r = rdc0;
    q0.push_back(vec[3].p);
    wait_rx0(base + 3);
    chk("mid_idx2", rx0[base+2], vec[3].p.addr);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("mid_tv", tv0, 0); chk("mid_busy", busy0, 0);
    chk("mid_fc", fc0, 0); chk("mid_rd", rd0, 0);
    chk("mid_pops", rdc0 - r, 1);
    step(1); rst_n = 1'b1; step(2);
    base = rx0.size();
    q0.push_back(vec[1].p);
    wait_rx0(base + 5);
    step(2);
    check_frame(base, vec[1], 1'b1);
    chk("post_rst_fc", fc0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", fails);
    $fatal(1);
  end
endmodule
